// File: rtl/win_gen_3x3.sv
// Raster-to-window generator for the 3x3 Gaussian filter stage.
// Buffers the two previous image lines and emits one packed 3x3 neighbourhood
// per accepted pixel once a full window exists (x>=2, y>=2), one cycle later.
module win_gen_3x3 #(
   parameter int unsigned DSIZE = 8,
   parameter int unsigned IMG_W = 640,
   parameter int unsigned IMG_H = 480
) (
   input  logic                 i_clk,
   input  logic                 i_rst_n,
   input  logic                 i_sof,
   input  logic                 i_valid,
   input  logic [DSIZE-1:0]     i_pixel,
   output logic                 o_valid,
   output logic [DSIZE*9-1:0]   o_window,
   output logic                 o_eof
);

   localparam int unsigned XW = $clog2(IMG_W);
   localparam int unsigned YW = $clog2(IMG_H);

   logic [XW-1:0]    x_q, x_d, x_cur;
   logic [YW-1:0]    y_q, y_d, y_cur;
   logic             last_x, last_y, win_ok;
   logic             valid_q, eof_q;
   logic [DSIZE-1:0] lb0 [IMG_W];
   logic [DSIZE-1:0] lb1 [IMG_W];
   logic [DSIZE-1:0] lb0_rd, lb1_rd;
   logic [DSIZE-1:0] win_q [9];
   logic [DSIZE-1:0] win_d [9];

   // Effective position of the presented pixel (i_sof forces (0,0)) and next counters.
   always_comb begin
      x_cur  = i_sof ? '0 : x_q;
      y_cur  = i_sof ? '0 : y_q;
      last_x = (x_cur == XW'(IMG_W - 1));
      last_y = (y_cur == YW'(IMG_H - 1));
      win_ok = (x_cur >= XW'(2)) && (y_cur >= YW'(2));
      x_d    = last_x ? '0 : x_cur + XW'(1);
      y_d    = y_cur;
      if (last_x) begin
         y_d = last_y ? '0 : y_cur + YW'(1);
      end
   end

   // Asynchronous line-buffer read at the current column, ahead of the write.
   always_comb begin
      lb0_rd = lb0[x_cur];
      lb1_rd = lb1[x_cur];
   end

   // Shift the window one column toward the oldest; newest column is rows y-2, y-1, y.
   always_comb begin
      for (int k = 0; k < 6; k++) begin
         win_d[k] = win_q[k+3];
      end
      win_d[6] = lb1_rd;
      win_d[7] = lb0_rd;
      win_d[8] = i_pixel;
   end

   // Line buffers: LB1 takes the old LB0 entry, LB0 takes the new pixel; contents not reset.
   always_ff @(posedge i_clk) begin
      if (i_valid) begin
         lb1[x_cur] <= lb0_rd;
         lb0[x_cur] <= i_pixel;
      end
   end

   // Counters, window registers and registered output strobes; idle cycles hold state.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         x_q     <= '0;
         y_q     <= '0;
         valid_q <= 1'b0;
         eof_q   <= 1'b0;
         win_q   <= '{default: '0};
      end else if (i_valid) begin
         x_q     <= x_d;
         y_q     <= y_d;
         win_q   <= win_d;
         valid_q <= win_ok;
         eof_q   <= win_ok && last_x && last_y;
      end else begin
         valid_q <= 1'b0;
         eof_q   <= 1'b0;
      end
   end

   // Pack column-major with index 0 in the most significant field.
   always_comb begin
      o_window = '0;
      for (int k = 0; k < 9; k++) begin
         o_window[DSIZE*9-1-k*DSIZE -: DSIZE] = win_q[k];
      end
      o_valid = valid_q;
      o_eof   = eof_q;
   end

endmodule
